// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, zero-seed guard,
// period measurement and a threshold comparator for an LED/GPIO pin.
module lfsr_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             led,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lock_err
);
    logic [WIDTH-1:0] start, cnt, nxt, cnt_inc, seed_v;
    logic             seed_zero;
    assign nxt       = {state[WIDTH-2:0], ^(state & TAPS)};
    // saturating so a maximal-length run still reports all ones
    assign cnt_inc   = &cnt ? cnt : cnt + WIDTH'(1);
    assign seed_zero = load_data == '0;
    assign seed_v    = seed_zero ? SEED : load_data;
    assign bit_out   = state[WIDTH-1];
    assign led       = state > thresh;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEED;
            start        <= SEED;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lock_err     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            lock_err     <= 1'b0;
            if (load) begin
                state    <= seed_v;
                start    <= seed_v;
                cnt      <= '0;
                lock_err <= seed_zero;
            end else if (en) begin
                state <= nxt;
                cnt   <= (nxt == start) ? '0 : cnt_inc;
                if (nxt == start) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed stimulus with a scoreboard queue for the default
// 4-bit LFSR, plus a free-running 8-bit instance checked for its period.
module tb_lfsr_gen;
    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [3:0] load_data, thresh;
    logic [3:0] state, period;
    logic       bit_out, led, period_valid, lock_err;
    logic       rst8, en8;
    logic [7:0] state8, period8;
    logic       bit8, led8, pv8, le8;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_gen u4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
        .thresh(thresh), .state(state), .bit_out(bit_out), .led(led),
        .period(period), .period_valid(period_valid), .lock_err(lock_err)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF)) u8 (
        .clk(clk), .rst(rst8), .en(en8), .load(1'b0), .load_data(8'h00),
        .thresh(8'h80), .state(state8), .bit_out(bit8), .led(led8),
        .period(period8), .period_valid(pv8), .lock_err(le8)
    );

    typedef struct {
        logic [3:0] st;
        logic [3:0] per;
        logic       pv;
        logic       le;
    } exp_t;
    exp_t q[$];

    // bench-side reference: taps 1100 means feedback = s[3] ^ s[2]
    logic [3:0] m_st, m_start, m_cnt, m_per;
    logic       m_pv, m_le;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic l,
                         input logic [3:0] ld, input logic e);
        exp_t x;
        logic [3:0] n, c1;
        rst = r; load = l; load_data = ld; en = e;
        if (r) begin
            m_st = 4'hF; m_start = 4'hF; m_cnt = 0; m_per = 0; m_pv = 0; m_le = 0;
        end else if (l) begin
            m_st = (ld == 0) ? 4'hF : ld;
            m_start = m_st; m_cnt = 0; m_pv = 0; m_le = (ld == 0);
        end else if (e) begin
            n  = {m_st[2:0], m_st[3] ^ m_st[2]};
            c1 = (m_cnt == 4'hF) ? 4'hF : m_cnt + 4'd1;
            m_st = n; m_le = 0;
            if (n == m_start) begin
                m_per = c1; m_pv = 1; m_cnt = 0;
            end else begin
                m_cnt = c1; m_pv = 0;
            end
        end else begin
            m_pv = 0; m_le = 0;
        end
        x.st = m_st; x.per = m_per; x.pv = m_pv; x.le = m_le;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk({tag, ".state"}, state, x.st);
        chk({tag, ".period"}, period, x.per);
        chk({tag, ".pvalid"}, period_valid, x.pv);
        chk({tag, ".lock_err"}, lock_err, x.le);
        chk({tag, ".led"}, led, x.st > thresh);
        chk({tag, ".bit_out"}, bit_out, x.st[3]);
    endtask

    logic [3:0] seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                             4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

    initial begin
        int steps;
        logic zero_seen;
        rst = 0; en = 0; load = 0; load_data = 0; thresh = 4'd10;
        rst8 = 1; en8 = 1;
        drive("reset", 1, 0, 0, 0);
        chk("reset.led_const", led, 1);
        rst8 = 0;
        for (int i = 0; i < 15; i++) begin
            drive("run15", 0, 0, 0, 1);
            chk("run15.seq", state, seq[i]);
            chk("run15.led_set", led, seq[i] inside {4'hE, 4'hC, 4'hD, 4'hB, 4'hF});
        end
        chk("run15.period_const", period, 15);
        chk("run15.pv_const", period_valid, 1);
        drive("zero_load", 0, 1, 0, 1);
        chk("zero_load.state_const", state, 4'hF);
        chk("zero_load.lock_const", lock_err, 1);
        drive("zero_hold", 0, 0, 0, 0);
        chk("zero_hold.lock_const", lock_err, 0);
        drive("load6", 0, 1, 4'h6, 0);
        for (int i = 0; i < 7; i++) drive("p6a", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive("p6hold", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive("p6b", 0, 0, 0, 1);
        chk("p6.state_const", state, 4'h6);
        chk("p6.pv_const", period_valid, 1);
        chk("p6.period_const", period, 15);
        drive("load4", 0, 1, 4'h4, 0);
        drive("to9", 0, 0, 0, 1);
        chk("to9.state_const", state, 4'h9);
        drive("midrst", 1, 1, 4'h5, 1);
        chk("midrst.state_const", state, 4'hF);
        chk("midrst.period_const", period, 0);
        drive("loadB", 0, 1, 4'hB, 0);
        drive("holdB", 0, 0, 0, 0);
        thresh = 4'hA; #1;
        chk("sweep.t10", led, 1);
        thresh = 4'hB; #1;
        chk("sweep.t11", led, 0);
        thresh = 4'hA;
        drive("loadF", 0, 1, 4'hF, 0);
        for (int i = 0; i < 14; i++) drive("pre_wrap", 0, 0, 0, 1);
        chk("pre_wrap.state_const", state, 4'h7);
        drive("load_wins", 0, 1, 4'h5, 1);
        chk("load_wins.pv_const", period_valid, 0);
        chk("load_wins.state_const", state, 4'h5);
        // 8-bit instance has been free-running since rst8 dropped
        steps = 0;
        zero_seen = 0;
        wait (period_valid == 0);
        rst8 = 1; @(posedge clk); #1; rst8 = 0;
        chk("w8.reset_state", state8, 8'hFF);
        while (steps < 300) begin
            @(posedge clk); #1;
            steps++;
            if (state8 == 0) zero_seen = 1;
            if (pv8) break;
        end
        chk("w8.steps", steps, 255);
        chk("w8.period", period8, 255);
        chk("w8.state_back", state8, 8'hFF);
        chk("w8.nonzero", zero_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR with stepping enable, runtime seed load, zero-seed protection, cycle-period measurement and a runtime-programmable threshold comparator driving an LED/GPIO output. It generalises the team's fixed 4-bit LFSR demo in three ways: WIDTH/TAPS/SEED become parameters, and seed load and period reporting are added. It sits between board-level clock/reset and a GPIO pin, and it also serves as a pseudo-random source for other demo blocks.

## Interface
- WIDTH, 4: LFSR width in bits. Legal range 3..32.
- TAPS, 4'b1100: feedback tap mask. Feedback is the XOR of `state & TAPS`.
- SEED, all ones: reset value, and the substitute value used when a zero seed is loaded. Must be non-zero.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- en  input  1  advance the LFSR one step per cycle while high.
- load  input  1  single-cycle strobe that loads `load_data`.
- load_data  input  WIDTH  seed value to load.
- thresh  input  WIDTH  comparator threshold.
- state  output  WIDTH  current LFSR register.
- bit_out  output  1  equals `state[WIDTH-1]`.
- led  output  1  equals `(state > thresh)`, unsigned compare.
- period  output  WIDTH  step count of the last completed cycle.
- period_valid  output  1  one-cycle pulse when `period` updates.
- lock_err  output  1  one-cycle pulse when a zero seed was substituted.

## Operation
- Step rule: `next = {state[WIDTH-2:0], ^(state & TAPS)}`, i.e. shift left and insert the feedback at the LSB.
- Priority per cycle: `rst` > `load` > `en` > hold.
- Load:
  - `state <= (load_data == 0) ? SEED : load_data`.
  - The start register captures the same value.
  - The step counter clears to 0.
  - `lock_err <= (load_data == 0)`.
  - No step occurs in a load cycle, even if `en` is high.
- Step (`en` high, no load):
  - `state <= next` and `cnt <= cnt + 1`.
  - If `next == start`: `period <= cnt + 1`, `period_valid <= 1`, `cnt <= 0`.
- Counter width:
  - `cnt` is WIDTH bits and saturates at all ones; it never wraps.
  - With saturated `cnt` and `next == start`, `period` reports all ones. This covers the 2^WIDTH-1 maximal period exactly, since all ones equals 2^WIDTH-1.
- Hold (`en` low, no load): `state`, `cnt` and `start` are unchanged; `period` holds; pulses deassert.
- `period_valid` and `lock_err` are high for exactly one cycle per event, otherwise 0.
- `led` and `bit_out` are combinational from the `state` register and `thresh`; there is no extra register stage.
- Zero state cannot be entered from reset or via load. Non-primitive TAPS simply give shorter periods, which `period` reports; this is not an error.

## Timing
- Reset values:
  - state = SEED, start = SEED, cnt = 0.
  - period = 0, period_valid = 0, lock_err = 0.
  - led = (SEED > thresh), bit_out = SEED[WIDTH-1].
- Step latency: `state` reflects the step at the edge that samples `en` high, i.e. 1 cycle.
- Load latency: 1 cycle. `lock_err` is high in the first cycle the substituted state is visible.
- `period_valid` rises in the same cycle `state` returns to `start`.
- `led` changes in the same cycle as `state` or `thresh`.
- Reset mid-run, asserted with `load` and/or `en` also high: reset wins, all reset values apply next cycle, and any pending period report is lost.
- Load in the same cycle a period would complete: load wins, with no `period_valid` pulse.
- A `period` update requires a full return to `start`. Holding `en` low mid-cycle only delays it and does not change the count.

## Test plan
- **Default params, reset, then `en` high 15 cycles.**
  - States: 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111.
  - On the 15th: `period_valid` = 1 and `period` = 15.
  - With `thresh` = 10, `led` high exactly at 1110, 1100, 1101, 1011, 1111.
- **`load` = 1 with `load_data` = 0000 and `en` = 1.**
  - Next cycle: `state` = 1111, `lock_err` = 1 for one cycle, no step.
- **Load 0110, then step 15 cycles with `en` low for 3 cycles mid-run.**
  - `period_valid` fires when `state` returns to 0110, with `period` = 15.
- **Reset mid-run.**
  - Assert `rst` with `load` = 1 at state 1001: next cycle `state` = 1111, `period` = 0, both pulses 0.
- **`thresh` sweep.**
  - `state` held at 1011: `thresh` = 1010 gives `led` = 1; `thresh` = 1011 gives `led` = 0 (combinational).
- **WIDTH = 8, TAPS = 8'hB8, SEED = 8'hFF, free-run.**
  - `period_valid` after exactly 255 steps with `period` = 255.
  - `state` is never 0 during the run.
